// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter
//
// Shares the single-port local DMEM between the core load/store unit and
// the network endpoint's incoming remote requests. One access is granted
// per cycle: the core has fixed priority, but a starvation counter forces
// a network grant once the network has been blocked starve_limit_p cycles
// in a row. Read data (1-cycle DMEM latency) is steered back to whichever
// requester issued the read. The block also holds the load-reserved (LR)
// reservation, which a network store to the reserved word breaks.
//
// Handshake: a requester holds *_v_i with its request fields stable; the
// request is consumed in the cycle *_yumi_o is high (same-cycle,
// combinational accept). Read responses have no backpressure: *_rdata_v_o
// pulses for exactly one cycle, the cycle after the read was accepted, and
// the requester must take it.
//
// Ports:
//   clk_i, reset_i                    clock, synchronous active-high reset
//   core_{v,w,addr,data,mask}_i       core request
//   core_reserve_i                    core read is LR (sets reservation)
//   core_clear_reserve_i              core drops its reservation
//   core_yumi_o                       core request accepted this cycle
//   core_rdata_v_o, core_rdata_o      core read response
//   net_{v,w,addr,data,mask}_i        network request
//   net_yumi_o                        network request accepted this cycle
//   net_rdata_v_o, net_rdata_o        network read response
//   dmem_{v,w,addr,data,mask}_o       DMEM port
//   dmem_data_i                       DMEM read data, valid a cycle after a read
//   reserved_o, reserve_addr_o        reservation state

module dmem_access_arbiter #(
  parameter int data_width_p   = 32,
  parameter int dmem_size_p    = 1024,
  parameter int starve_limit_p = 4,
  localparam int mask_width_lp = data_width_p >> 3,
  localparam int addr_width_lp = (dmem_size_p > 1) ? $clog2(dmem_size_p) : 1,
  localparam int cnt_width_lp  = (starve_limit_p > 0) ? $clog2(starve_limit_p + 1) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     core_v_i,
  input  logic                     core_w_i,
  input  logic [addr_width_lp-1:0] core_addr_i,
  input  logic [data_width_p-1:0]  core_data_i,
  input  logic [mask_width_lp-1:0] core_mask_i,
  input  logic                     core_reserve_i,
  input  logic                     core_clear_reserve_i,
  output logic                     core_yumi_o,
  output logic                     core_rdata_v_o,
  output logic [data_width_p-1:0]  core_rdata_o,

  input  logic                     net_v_i,
  input  logic                     net_w_i,
  input  logic [addr_width_lp-1:0] net_addr_i,
  input  logic [data_width_p-1:0]  net_data_i,
  input  logic [mask_width_lp-1:0] net_mask_i,
  output logic                     net_yumi_o,
  output logic                     net_rdata_v_o,
  output logic [data_width_p-1:0]  net_rdata_o,

  output logic                     dmem_v_o,
  output logic                     dmem_w_o,
  output logic [addr_width_lp-1:0] dmem_addr_o,
  output logic [data_width_p-1:0]  dmem_data_o,
  output logic [mask_width_lp-1:0] dmem_mask_o,
  input  logic [data_width_p-1:0]  dmem_data_i,

  output logic                     reserved_o,
  output logic [addr_width_lp-1:0] reserve_addr_o
);

  localparam logic [cnt_width_lp-1:0] starve_max_lp = cnt_width_lp'(starve_limit_p);

  logic [cnt_width_lp-1:0]  starve_cnt_q;
  logic                     rd_pending_q;
  logic                     rd_owner_q;   // 0 = core, 1 = network
  logic                     reserved_q;
  logic [addr_width_lp-1:0] reserve_addr_q;

  logic force_net;
  logic core_grant;
  logic net_grant;
  logic rsv_set;
  logic rsv_clear;

  // Grants are suppressed while reset is held so no access starts (and no
  // response is scheduled) during reset.
  always_comb begin
    force_net  = net_v_i & (starve_cnt_q == starve_max_lp);
    core_grant = ~reset_i & core_v_i & ~force_net;
    net_grant  = ~reset_i & net_v_i & ~core_grant;
  end

  assign core_yumi_o = core_grant;
  assign net_yumi_o  = net_grant;

  // DMEM port follows the granted requester; fields are don't-care when
  // dmem_v_o is low, so the core side is used as the default.
  always_comb begin
    dmem_v_o    = core_grant | net_grant;
    dmem_w_o    = net_grant ? net_w_i    : core_w_i;
    dmem_addr_o = net_grant ? net_addr_i : core_addr_i;
    dmem_data_o = net_grant ? net_data_i : core_data_i;
    dmem_mask_o = net_grant ? net_mask_i : core_mask_i;
  end

  // Response valid is masked by reset so a reset in the cycle after a read
  // grant swallows that response.
  assign core_rdata_v_o = rd_pending_q & ~rd_owner_q & ~reset_i;
  assign net_rdata_v_o  = rd_pending_q &  rd_owner_q & ~reset_i;
  assign core_rdata_o   = dmem_data_i;
  assign net_rdata_o    = dmem_data_i;

  // A new LR overrides a same-cycle clear.
  always_comb begin
    rsv_set   = core_grant & ~core_w_i & core_reserve_i;
    rsv_clear = core_clear_reserve_i
              | (net_grant & net_w_i & (net_addr_i == reserve_addr_q));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_cnt_q   <= '0;
      rd_pending_q   <= 1'b0;
      rd_owner_q     <= 1'b0;
      reserved_q     <= 1'b0;
      reserve_addr_q <= '0;
    end else begin
      // Counts cycles the network waits behind the core; any other cycle
      // (network granted or idle) restarts the count.
      if (net_v_i & core_grant) begin
        if (starve_cnt_q != starve_max_lp)
          starve_cnt_q <= starve_cnt_q + cnt_width_lp'(1);
      end else begin
        starve_cnt_q <= '0;
      end

      rd_pending_q <= (core_grant & ~core_w_i) | (net_grant & ~net_w_i);
      if (core_grant | net_grant)
        rd_owner_q <= net_grant;

      if (rsv_set) begin
        reserved_q     <= 1'b1;
        reserve_addr_q <= core_addr_i;
      end else if (rsv_clear) begin
        reserved_q <= 1'b0;
      end
    end
  end

  assign reserved_o     = reserved_q;
  assign reserve_addr_o = reserve_addr_q;

endmodule
